// File: rtl/parity_pkg.sv
// Shared constants and helpers for the parity generator and its checkers.
package parity_pkg;

  // Reset value of odd: parity of the all-zero word.
  localparam logic PARITY_RST_ODD = 1'b0;
  localparam int   PARITY_MAX_W   = 64;

  // Reference parity of the low w bits of v (1 = odd number of ones).
  function automatic logic parity_odd(logic [63:0] v, int w);
    logic p;
    p = 1'b0;
    for (int i = 0; i < PARITY_MAX_W; i++)
      if (i < w) p = p ^ v[i];
    return p;
  endfunction

  // Node count at tree level k for a w-bit input: ceil(w / 2^k).
  function automatic int tree_w(int w, int k);
    return (w + (1 << k) - 1) >> k;
  endfunction

endpackage

// File: rtl/parity_xor_tree.sv
// Balanced combinational XOR reduction: pairs nodes level by level, an odd
// leftover node is passed straight up to the next level.
module parity_xor_tree
  import parity_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  output logic             odd
);

  localparam int LEVELS = $clog2(WIDTH);

  // Each level lives in its own generate scope so its vector is sized exactly
  // to the node count; no padding bits are left dangling.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NI = tree_w(WIDTH, k);
    localparam int NO = tree_w(WIDTH, k + 1);
    logic [NI-1:0] src;
    logic [NO-1:0] nxt;

    if (k == 0) begin : g_first
      assign src = x;
    end else begin : g_chain
      assign src = g_lvl[k-1].nxt;
    end

    for (genvar j = 0; j < NO; j++) begin : g_node
      if (2*j + 1 < NI) begin : g_pair
        assign nxt[j] = src[2*j] ^ src[2*j+1];
      end else begin : g_pass
        assign nxt[j] = src[2*j];
      end
    end
  end

  if (LEVELS == 0) begin : g_single
    assign odd = x[0];
  end else begin : g_root
    assign odd = g_lvl[LEVELS-1].nxt[0];
  end

endmodule

// File: rtl/parity.sv
// Registered parity generator: one-cycle latency odd/even flags plus valid.
module parity
  import parity_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  output logic             odd,
  output logic             even,
  output logic             out_valid
);

  logic tree_odd;
  logic odd_q;
  logic vld_q;

  parity_xor_tree #(.WIDTH(WIDTH)) u_tree (
    .x   (x),
    .odd (tree_odd)
  );

  // Capture parity only for qualified words; otherwise hold, so X on an
  // unqualified x never reaches the register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      odd_q <= PARITY_RST_ODD;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) odd_q <= tree_odd;
    end
  end

  // even is derived from the same flop, so odd and even can never agree.
  assign odd       = odd_q;
  assign even      = ~odd_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_parity.sv
// Self-checking bench: reset, exhaustive 4-bit sweep, hold, mid-stream reset,
// and randomized 64-bit / 5-bit streams against a popcount-based model.
module tb_parity;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v4, v64, v5;
  logic [3:0]  x4;
  logic [63:0] x64;
  logic [4:0]  x5;
  logic o4, e4, ov4, o64, e64, ov64, o5, e5, ov5;

  parity #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .x(x4),
    .odd(o4), .even(e4), .out_valid(ov4));
  parity #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .x(x64),
    .odd(o64), .even(e64), .out_valid(ov64));
  parity #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .x(x5),
    .odd(o5), .even(e5), .out_valid(ov5));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] x;
    logic       vld;
    logic       exp_odd;
    logic       exp_vld;
  } vec_t;

  vec_t tbl[$];

  // model state for the wide/odd-width instances
  logic m64_odd, m64_vld, m5_odd, m5_vld;

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string tag, input logic eo, input logic ev);
    chk({tag, ".odd"},  o4,  eo);
    chk({tag, ".even"}, e4,  ~eo);
    chk({tag, ".vld"},  ov4, ev);
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spec-level model: parity is popcount mod 2; reset dominates; valid-low holds.
  task automatic model_update();
    if (!rst_n) begin
      m64_odd = 1'b0; m64_vld = 1'b0; m5_odd = 1'b0; m5_vld = 1'b0;
    end else begin
      if (v64) m64_odd = logic'($countones(x64) % 2);
      m64_vld = v64;
      if (v5)  m5_odd  = logic'($countones(x5) % 2);
      m5_vld  = v5;
    end
  endtask

  task automatic chk_wide(input string tag);
    chk({tag, ".o64"}, o64,  m64_odd);
    chk({tag, ".e64"}, e64,  ~m64_odd);
    chk({tag, ".v64"}, ov64, m64_vld);
    chk({tag, ".o5"},  o5,   m5_odd);
    chk({tag, ".e5"},  e5,   ~m5_odd);
    chk({tag, ".v5"},  ov5,  m5_vld);
  endtask

  task automatic drive_wide(input logic vv64, input logic [63:0] xx64,
                            input logic vv5, input logic [4:0] xx5);
    v64 = vv64; x64 = xx64; v5 = vv5; x5 = xx5;
    model_update();
    step();
    chk_wide("wide");
  endtask

  initial begin
    logic [15:0] seq;
    seq = 16'b0110_1001_1001_0110; // odd sequence for x = 0..15, read LSB first

    rst_n = 1'b0;
    v4 = 1'b1; x4 = 4'b0111;
    v64 = 1'b0; x64 = '0; v5 = 1'b0; x5 = '0;
    #1;

    // Reset held 3 cycles with a valid word presented: it must be discarded.
    for (int i = 0; i < 3; i++) begin
      step();
      chk4("reset", 1'b0, 1'b0);
    end

    // Table: exhaustive sweep, then hold with 0000 and with X on x.
    for (int i = 0; i < 16; i++)
      tbl.push_back('{x: 4'(i), vld: 1'b1, exp_odd: seq[i], exp_vld: 1'b1});
    tbl.push_back('{x: 4'b1011, vld: 1'b1, exp_odd: 1'b1, exp_vld: 1'b1});
    tbl.push_back('{x: 4'b0000, vld: 1'b0, exp_odd: 1'b1, exp_vld: 1'b0});
    tbl.push_back('{x: 4'bxxxx, vld: 1'b0, exp_odd: 1'b1, exp_vld: 1'b0});
    tbl.push_back('{x: 4'b0001, vld: 1'b1, exp_odd: 1'b1, exp_vld: 1'b1});

    rst_n = 1'b1;
    foreach (tbl[i]) begin
      v4 = tbl[i].vld; x4 = tbl[i].x;
      step();
      chk4($sformatf("tbl%0d", i), tbl[i].exp_odd, tbl[i].exp_vld);
    end

    // Mid-stream reset: 0001 -> 1, 0011 -> 0, then reset wins over a valid word.
    v4 = 1'b1; x4 = 4'b0001; step(); chk4("mid0", 1'b1, 1'b1);
    x4 = 4'b0011;            step(); chk4("mid1", 1'b0, 1'b1);
    x4 = 4'b0111; rst_n = 1'b0;
    step(); chk4("mid_rst", 1'b0, 1'b0);
    rst_n = 1'b1; v4 = 1'b0; x4 = 4'b0111;
    step(); chk4("post_idle", 1'b0, 1'b0);
    v4 = 1'b1;
    step(); chk4("post_first", 1'b1, 1'b1);
    v4 = 1'b0;
    step(); chk4("post_hold", 1'b1, 1'b0);

    // Wide / odd-width: realign model with a reset, then edge cases and random.
    rst_n = 1'b0;
    drive_wide(1'b1, '1, 1'b1, 5'b11111);
    rst_n = 1'b1;
    drive_wide(1'b1, '1, 1'b1, 5'b10000);
    drive_wide(1'b1, 64'h1, 1'b1, 5'b11111);
    drive_wide(1'b1, 64'h8000_0000_0000_0000, 1'b1, 5'b00000);
    drive_wide(1'b0, 64'h0, 1'b0, 5'b00001);
    for (int i = 0; i < 300; i++) begin
      drive_wide(($urandom_range(0, 3) != 0), {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0), 5'($urandom));
    end
    // Occasional mid-stream reset on the random streams.
    rst_n = 1'b0;
    drive_wide(1'b1, {$urandom, $urandom}, 1'b1, 5'($urandom));
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++)
      drive_wide(1'b1, {$urandom, $urandom}, 1'b1, 5'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
